// File: rtl/rattlesnake_csr_pkg.sv
// rattlesnake_csr_pkg: shared constants for the Rattlesnake machine-mode CSR unit.
// Contains CSR addresses, csr_op encodings, interrupt cause codes, mtvec modes
// and the read-modify-write helper shared by every CSR.
package rattlesnake_csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [4:0] CAUSE_MTI       = 5'd7;
  localparam logic [4:0] CAUSE_MEI       = 5'd11;
  localparam logic [4:0] CAUSE_FAST_BASE = 5'd16;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // New CSR value for an access; reserved op leaves the value untouched.
  function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                               input logic [31:0] old,
                                               input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old | wdata;
      CSR_OP_RC: res = old & ~wdata;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rattlesnake_irq_pending.sv
// rattlesnake_irq_pending: fast-interrupt edge capture, mip generation and
// the priority encoder producing the registered irq_req / irq_cause pair.
// The request is computed from next-cycle state so that it tracks enable
// changes and trap entry with exactly one cycle of latency.
module rattlesnake_irq_pending
  import rattlesnake_csr_pkg::*;
#(
  parameter int          NUM_FAST_IRQ  = 4,
  parameter logic [15:0] IRQ_EDGE_MASK = 16'h0000
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    timer_irq,
  input  logic                    ext_irq,
  input  logic [NUM_FAST_IRQ-1:0] fast_irq,
  input  logic                    sw_we,
  input  logic [NUM_FAST_IRQ-1:0] sw_wdata,
  input  logic                    trap_clr,
  input  logic [4:0]              trap_cause,
  input  logic                    mie_global,
  input  logic [31:0]             mie_en,
  output logic [31:0]             mip,
  output logic                    irq_req,
  output logic [4:0]              irq_cause
);

  localparam logic [NUM_FAST_IRQ-1:0] EDGE = IRQ_EDGE_MASK[NUM_FAST_IRQ-1:0];

  logic [NUM_FAST_IRQ-1:0] fast_prev;
  logic [NUM_FAST_IRQ-1:0] pending;
  logic [NUM_FAST_IRQ-1:0] pending_next;
  logic [NUM_FAST_IRQ-1:0] rise;
  logic [NUM_FAST_IRQ-1:0] clr;
  logic [31:0]             mip_next;
  logic [31:0]             active;
  logic [4:0]              cause;

  assign rise = fast_irq & ~fast_prev;

  // Edge pending update: a rising edge always wins over a software or trap clear.
  always_comb begin
    clr = {NUM_FAST_IRQ{1'b0}};
    for (int i = 0; i < NUM_FAST_IRQ; i++) begin
      clr[i] = (sw_we & ~sw_wdata[i]) |
               (trap_clr & (trap_cause == (CAUSE_FAST_BASE + 5'(i))));
    end
    pending_next = EDGE & (rise | (pending & ~clr));
  end

  // Current and next-cycle mip images (level bits mirror their inputs).
  always_comb begin
    mip      = 32'd0;
    mip_next = 32'd0;
    mip[7]   = timer_irq;
    mip[11]  = ext_irq;
    mip[16 +: NUM_FAST_IRQ] = (EDGE & pending) | (~EDGE & fast_irq);
    mip_next[7]  = timer_irq;
    mip_next[11] = ext_irq;
    mip_next[16 +: NUM_FAST_IRQ] = (EDGE & pending_next) | (~EDGE & fast_irq);
  end

  // Priority: lowest fast index, then MEI, then MTI (later assignment wins).
  always_comb begin
    active = mip_next & mie_en;
    cause  = 5'd0;
    cause  = active[7]  ? CAUSE_MTI : cause;
    cause  = active[11] ? CAUSE_MEI : cause;
    for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
      cause = active[16 + i] ? (CAUSE_FAST_BASE + 5'(i)) : cause;
    end
  end

  // Edge history, pending bits and the registered request outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fast_prev <= {NUM_FAST_IRQ{1'b0}};
      pending   <= {NUM_FAST_IRQ{1'b0}};
      irq_req   <= 1'b0;
      irq_cause <= 5'd0;
    end else begin
      fast_prev <= fast_irq;
      pending   <= pending_next;
      irq_req   <= mie_global & (|active);
      irq_cause <= cause;
    end
  end

endmodule

// File: rtl/rattlesnake_csr_irq.sv
// rattlesnake_csr_irq: machine-mode CSR file and interrupt unit for Rattlesnake.
// Access priority per cycle is trap_enter > mret > csr_valid; a losing CSR
// access is dropped silently. Build macro CSR_COUNTERS_EN adds the 64-bit
// mcycle/minstret counters and mcountinhibit; without it those addresses
// are illegal and no counter state exists.
module rattlesnake_csr_irq
  import rattlesnake_csr_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter int          NUM_FAST_IRQ  = 4,
  parameter logic [15:0] IRQ_EDGE_MASK = 16'h0000
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    exe_enable,
  input  logic                    csr_valid,
  input  logic [1:0]              csr_op,
  input  logic [11:0]             csr_addr,
  input  logic [XLEN-1:0]         csr_wdata,
  output logic                    csr_rdata_valid,
  output logic [XLEN-1:0]         csr_rdata,
  output logic                    csr_illegal,
  input  logic                    timer_irq,
  input  logic                    ext_irq,
  input  logic [NUM_FAST_IRQ-1:0] fast_irq,
  input  logic                    trap_enter,
  input  logic [4:0]              trap_cause,
  input  logic                    trap_is_irq,
  input  logic [XLEN-1:0]         trap_pc,
  input  logic [XLEN-1:0]         trap_tval,
  input  logic                    mret,
  output logic                    irq_req,
  output logic [4:0]              irq_cause,
  output logic [XLEN-1:0]         trap_target_pc,
  output logic [XLEN-1:0]         mepc_out
);

  localparam logic [31:0] MIE_MASK =
    32'h0000_0880 | (((32'd1 << NUM_FAST_IRQ) - 32'd1) << 16);

  logic        mstatus_mie, mstatus_mpie;
  logic        mstatus_mie_next, mstatus_mpie_next;
  logic [31:0] mie_en, mie_next;
  logic [29:0] mtvec_base;
  logic [1:0]  mtvec_mode;
  logic [31:0] mscratch, mepc, mcause, mtval;
  logic [31:0] mip_val;

  logic        do_csr, write_intent, access_illegal, csr_we, hit, read_only;
  logic [31:0] old_val, wval;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
  logic [2:0]  mcountinhibit;
`else
  logic unused_exe_enable;
  assign unused_exe_enable = exe_enable;
`endif

  assign do_csr       = csr_valid & ~trap_enter & ~mret;
  assign write_intent = (csr_op == CSR_OP_RW) | (csr_wdata != 32'd0);
  assign wval         = csr_apply_op(csr_op, old_val, csr_wdata);
  assign csr_we       = do_csr & ~access_illegal & write_intent;

  // CSR read mux and address decode.
  always_comb begin
    old_val   = 32'd0;
    hit       = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:  old_val = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      CSR_MIE:      old_val = mie_en;
      CSR_MTVEC:    old_val = {mtvec_base, mtvec_mode};
      CSR_MSCRATCH: old_val = mscratch;
      CSR_MEPC:     old_val = mepc;
      CSR_MCAUSE:   old_val = mcause;
      CSR_MTVAL:    old_val = mtval;
      CSR_MIP:      old_val = mip_val;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: read_only = 1'b1;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:        old_val = mcycle[31:0];
      CSR_MCYCLEH:       old_val = mcycle[63:32];
      CSR_MINSTRET:      old_val = minstret[31:0];
      CSR_MINSTRETH:     old_val = minstret[63:32];
      CSR_MCOUNTINHIBIT: old_val = {29'd0, mcountinhibit};
`endif
      default: hit = 1'b0;
    endcase
    access_illegal = ~hit | (csr_op == CSR_OP_NONE) | (read_only & write_intent);
  end

  // Next state of mstatus.MIE/MPIE and mie; also feeds the interrupt unit.
  always_comb begin
    mstatus_mie_next  = mstatus_mie;
    mstatus_mpie_next = mstatus_mpie;
    if (trap_enter) begin
      mstatus_mpie_next = mstatus_mie;
      mstatus_mie_next  = 1'b0;
    end else if (mret) begin
      mstatus_mie_next  = mstatus_mpie;
      mstatus_mpie_next = 1'b1;
    end else if (csr_we && (csr_addr == CSR_MSTATUS)) begin
      mstatus_mie_next  = wval[3];
      mstatus_mpie_next = wval[7];
    end else begin
      mstatus_mie_next  = mstatus_mie;
      mstatus_mpie_next = mstatus_mpie;
    end
    if (csr_we && (csr_addr == CSR_MIE)) begin
      mie_next = wval & MIE_MASK;
    end else begin
      mie_next = mie_en;
    end
  end

  // Handler PC: vectored only for interrupts in MODE=1.
  assign trap_target_pc = ((mtvec_mode == MTVEC_VECTORED) && trap_is_irq) ?
                          ({mtvec_base, 2'b00} + {25'd0, trap_cause, 2'b00}) :
                          {mtvec_base, 2'b00};
  assign mepc_out = mepc;

  rattlesnake_irq_pending #(
    .NUM_FAST_IRQ  (NUM_FAST_IRQ),
    .IRQ_EDGE_MASK (IRQ_EDGE_MASK)
  ) u_irq_pending (
    .clk        (clk),
    .reset      (reset),
    .timer_irq  (timer_irq),
    .ext_irq    (ext_irq),
    .fast_irq   (fast_irq),
    .sw_we      (csr_we & (csr_addr == CSR_MIP)),
    .sw_wdata   (wval[16 +: NUM_FAST_IRQ]),
    .trap_clr   (trap_enter & trap_is_irq),
    .trap_cause (trap_cause),
    .mie_global (mstatus_mie_next),
    .mie_en     (mie_next),
    .mip        (mip_val),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause)
  );

  // CSR state, trap stacking and the registered read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
      mie_en          <= 32'd0;
      mtvec_base      <= 30'd0;
      mtvec_mode      <= 2'd0;
      mscratch        <= 32'd0;
      mepc            <= 32'd0;
      mcause          <= 32'd0;
      mtval           <= 32'd0;
      csr_rdata_valid <= 1'b0;
      csr_illegal     <= 1'b0;
      csr_rdata       <= 32'd0;
    end else begin
      mstatus_mie     <= mstatus_mie_next;
      mstatus_mpie    <= mstatus_mpie_next;
      mie_en          <= mie_next;
      csr_rdata_valid <= do_csr;
      csr_illegal     <= do_csr & access_illegal;
      csr_rdata       <= (do_csr & ~access_illegal) ? old_val : 32'd0;
      if (trap_enter) begin
        mepc   <= trap_pc & ~32'd3;
        mcause <= {trap_is_irq, 26'd0, trap_cause};
        mtval  <= trap_tval;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MTVEC: begin
            // MODE 2/3 are reserved: keep the old mode, still take the base.
            mtvec_base <= wval[31:2];
            mtvec_mode <= wval[1] ? mtvec_mode : wval[1:0];
          end
          CSR_MSCRATCH: mscratch <= wval;
          CSR_MEPC:     mepc     <= wval & ~32'd3;
          CSR_MCAUSE:   mcause   <= wval;
          CSR_MTVAL:    mtval    <= wval;
          default: begin
          end
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // Free-running counters; a write to either half replaces it and skips that increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle        <= 64'd0;
      minstret      <= 64'd0;
      mcountinhibit <= 3'd0;
    end else begin
      if (csr_we && (csr_addr == CSR_MCOUNTINHIBIT)) begin
        mcountinhibit <= wval[2:0] & 3'b101;
      end
      if (csr_we && (csr_addr == CSR_MCYCLE)) begin
        mcycle[31:0] <= wval;
      end else if (csr_we && (csr_addr == CSR_MCYCLEH)) begin
        mcycle[63:32] <= wval;
      end else if (!mcountinhibit[0]) begin
        mcycle <= mcycle + 64'd1;
      end
      if (csr_we && (csr_addr == CSR_MINSTRET)) begin
        minstret[31:0] <= wval;
      end else if (csr_we && (csr_addr == CSR_MINSTRETH)) begin
        minstret[63:32] <= wval;
      end else if (exe_enable && !mcountinhibit[2]) begin
        minstret <= minstret + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rattlesnake_csr_irq.sv
// tb_rattlesnake_csr_irq: directed bench for rattlesnake_csr_irq.
// CSR accesses push their expected response into a scoreboard queue; a
// monitor pops and compares whenever csr_rdata_valid is presented.
module tb_rattlesnake_csr_irq;
  import rattlesnake_csr_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          exe_enable, csr_valid;
  logic [1:0]    csr_op;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata, csr_rdata;
  logic          csr_rdata_valid, csr_illegal;
  logic          timer_irq, ext_irq;
  logic [N-1:0]  fast_irq;
  logic          trap_enter, trap_is_irq, mret;
  logic [4:0]    trap_cause, irq_cause;
  logic [31:0]   trap_pc, trap_tval, trap_target_pc, mepc_out;
  logic          irq_req;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data[$];
  logic [31:0] exp_mask[$];
  logic        exp_ill[$];
  string       exp_name[$];

  rattlesnake_csr_irq #(
    .XLEN(32), .NUM_FAST_IRQ(N), .IRQ_EDGE_MASK(16'h0001)
  ) dut (
    .clk(clk), .reset(reset), .exe_enable(exe_enable),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata_valid(csr_rdata_valid),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .timer_irq(timer_irq), .ext_irq(ext_irq), .fast_irq(fast_irq),
    .trap_enter(trap_enter), .trap_cause(trap_cause), .trap_is_irq(trap_is_irq),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
    .irq_req(irq_req), .irq_cause(irq_cause),
    .trap_target_pc(trap_target_pc), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compare each presented response with the queue head.
  always @(negedge clk) begin
    if (!reset && csr_illegal && !csr_rdata_valid) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL illegal_without_valid got ill=1 valid=0 required ill=0");
    end
    if (!reset && csr_rdata_valid) begin
      checks = checks + 1;
      if (exp_data.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_rdata_valid got rdata=%h ill=%b required no response",
                 csr_rdata, csr_illegal);
      end else begin
        logic [31:0] d, m;
        logic        il;
        string       nm;
        d = exp_data.pop_front();
        m = exp_mask.pop_front();
        il = exp_ill.pop_front();
        nm = exp_name.pop_front();
        if (((csr_rdata & m) !== (d & m)) || (csr_illegal !== il)) begin
          errors = errors + 1;
          $display("FAIL %s got rdata=%h ill=%b required rdata=%h (mask %h) ill=%b",
                   nm, csr_rdata, csr_illegal, d, m, il);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      errors = errors + 1;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w,
                     input logic [31:0] e, input logic [31:0] m, input logic il,
                     input string nm);
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = w;
    exp_data.push_back(e); exp_mask.push_back(m);
    exp_ill.push_back(il); exp_name.push_back(nm);
    step();
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = 32'd0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    csr(CSR_OP_RS, a, 32'd0, e, 32'hFFFF_FFFF, 1'b0, nm);
  endtask

  task automatic trap(input logic irq, input logic [4:0] c, input logic [31:0] pc,
                      input logic [31:0] tv);
    trap_enter = 1'b1; trap_is_irq = irq; trap_cause = c; trap_pc = pc; trap_tval = tv;
    step();
    trap_enter = 1'b0;
  endtask

  initial begin
    reset = 1'b1; exe_enable = 1'b0; csr_valid = 1'b0; csr_op = 2'b00;
    csr_addr = 12'h000; csr_wdata = 32'd0; timer_irq = 1'b0; ext_irq = 1'b0;
    fast_irq = 4'b0000; trap_enter = 1'b0; trap_is_irq = 1'b0; mret = 1'b0;
    trap_cause = 5'd0; trap_pc = 32'd0; trap_tval = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata_valid", {31'd0, csr_rdata_valid}, 32'd0);
    chk("reset_illegal", {31'd0, csr_illegal}, 32'd0);
    chk("reset_irq_req", {31'd0, irq_req}, 32'd0);
    chk("reset_irq_cause", {27'd0, irq_cause}, 32'd0);
    chk("reset_mepc", mepc_out, 32'd0);
    chk("reset_target_pc", trap_target_pc, 32'd0);
    reset = 1'b0;
    step();

    rd(CSR_MSTATUS, 32'h0000_1800, "mstatus_reset");
    rd(12'h7C0, 32'd0, "unimpl_read");
    exp_ill[exp_ill.size() - 1] = 1'b1;

    // mtvec vectored target and MODE=2 write
    csr(CSR_OP_RW, CSR_MTVEC, 32'h8000_0101, 32'd0, 32'hFFFF_FFFF, 1'b0, "mtvec_rw");
    rd(CSR_MTVEC, 32'h8000_0101, "mtvec_read");
    trap_cause = 5'd17; trap_is_irq = 1'b1; #1;
    chk("target_vectored", trap_target_pc, 32'h8000_0144);
    trap_is_irq = 1'b0; #1;
    chk("target_exception", trap_target_pc, 32'h8000_0100);
    trap(1'b1, 5'd17, 32'h0000_1236, 32'h0000_0ABC);
    chk("mepc_aligned", mepc_out, 32'h0000_1234);
    rd(CSR_MCAUSE, 32'h8000_0011, "mcause_irq");
    rd(CSR_MTVAL, 32'h0000_0ABC, "mtval");
    csr(CSR_OP_RW, CSR_MTVEC, 32'h8000_0202, 32'h8000_0101, 32'hFFFF_FFFF, 1'b0, "mtvec_mode2");
    rd(CSR_MTVEC, 32'h8000_0201, "mtvec_mode_kept");

    // edge-sensitive fast_irq[0]
    csr(CSR_OP_RW, CSR_MIE, 32'h0001_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, "mie_write");
    csr(CSR_OP_RS, CSR_MSTATUS, 32'h0000_0008, 32'h0000_1800, 32'hFFFF_FFFF, 1'b0, "mstatus_set_mie");
    chk("irq_idle", {31'd0, irq_req}, 32'd0);
    fast_irq = 4'b0001; step(); fast_irq = 4'b0000;
    chk("edge_irq_req", {31'd0, irq_req}, 32'd1);
    chk("edge_irq_cause", {27'd0, irq_cause}, 32'd16);
    rd(CSR_MIP, 32'h0001_0000, "mip_edge_pending");
    chk("edge_irq_held", {31'd0, irq_req}, 32'd1);
    trap_is_irq = 1'b1; trap_cause = 5'd16; #1;
    chk("target_fast0", trap_target_pc, 32'h8000_0240);
    trap(1'b1, 5'd16, 32'h0000_2000, 32'd0);
    chk("irq_drop_after_trap", {31'd0, irq_req}, 32'd0);
    chk("mepc_trap2", mepc_out, 32'h0000_2000);
    rd(CSR_MSTATUS, 32'h0000_1880, "mstatus_after_trap");
    mret = 1'b1; step(); mret = 1'b0;
    rd(CSR_MSTATUS, 32'h0000_1888, "mstatus_after_mret");
    chk("pending_cleared_by_trap", {31'd0, irq_req}, 32'd0);
    rd(CSR_MIP, 32'd0, "mip_after_trap");

    // software clear, and rising edge beating a concurrent clear
    fast_irq = 4'b0001; step(); fast_irq = 4'b0000;
    chk("edge2_irq_req", {31'd0, irq_req}, 32'd1);
    csr(CSR_OP_RC, CSR_MIP, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, "mip_sw_clear");
    chk("irq_after_sw_clear", {31'd0, irq_req}, 32'd0);
    fast_irq = 4'b0001;
    csr(CSR_OP_RC, CSR_MIP, 32'h0001_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, "mip_clear_vs_edge");
    fast_irq = 4'b0000;
    chk("edge_wins_clear", {31'd0, irq_req}, 32'd1);
    rd(CSR_MIP, 32'h0001_0000, "mip_edge_won");
    csr(CSR_OP_RC, CSR_MIP, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, "mip_clear2");
    chk("irq_after_clear2", {31'd0, irq_req}, 32'd0);

    // level fast_irq[1] against MEI, then MTI enable
    csr(CSR_OP_RS, CSR_MIE, 32'h0002_0800, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, "mie_set_17_11");
    fast_irq = 4'b0010; ext_irq = 1'b1; step();
    chk("both_irq_req", {31'd0, irq_req}, 32'd1);
    chk("fast_beats_mei", {27'd0, irq_cause}, 32'd17);
    rd(CSR_MIP, 32'h0002_0800, "mip_level");
    fast_irq = 4'b0000; step();
    chk("mei_cause", {27'd0, irq_cause}, 32'd11);
    ext_irq = 1'b0; timer_irq = 1'b1; step();
    chk("mti_masked", {31'd0, irq_req}, 32'd0);
    csr(CSR_OP_RS, CSR_MIE, 32'h0000_0080, 32'h0003_0800, 32'hFFFF_FFFF, 1'b0, "mie_set_7");
    chk("mti_req", {31'd0, irq_req}, 32'd1);
    chk("mti_cause", {27'd0, irq_cause}, 32'd7);
    timer_irq = 1'b0; step();
    chk("mti_gone", {31'd0, irq_req}, 32'd0);

    // read-only ID registers and reserved op
    csr(CSR_OP_RS, CSR_MHARTID, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, "mhartid_rs0");
    csr(CSR_OP_RW, CSR_MHARTID, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "mhartid_rw");
    csr(CSR_OP_RC, CSR_MVENDORID, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, "mvendorid_rc0");
    csr(CSR_OP_RS, CSR_MARCHID, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, "marchid_rs1");
    rd(CSR_MHARTID, 32'd0, "mhartid_unchanged");
    csr(CSR_OP_RW, CSR_MSCRATCH, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1'b0, "mscratch_rw");
    csr(CSR_OP_NONE, CSR_MSCRATCH, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, "op_reserved");
    csr(CSR_OP_RC, CSR_MSCRATCH, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, "mscratch_rc");
    rd(CSR_MSCRATCH, 32'hDEAD_0000, "mscratch_after_rc");

    // access losing to trap_enter and to mret
    csr_valid = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h1;
    trap(1'b0, 5'd3, 32'h0000_0040, 32'd0);
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = 32'd0;
    step();
    chk("mepc_trap3", mepc_out, 32'h0000_0040);
    rd(CSR_MSTATUS, 32'h0000_1880, "mstatus_trap3");
    rd(CSR_MCAUSE, 32'h0000_0003, "mcause_exc");
    csr_valid = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h2;
    mret = 1'b1; step(); mret = 1'b0;
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = 32'd0;
    step();
    rd(CSR_MSCRATCH, 32'hDEAD_0000, "mscratch_not_written");
    rd(CSR_MSTATUS, 32'h0000_1888, "mstatus_mret2");

`ifdef CSR_COUNTERS_EN
    csr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'h0000_0004, 32'd0, 32'hFFFF_FFFF, 1'b0, "inhibit_ir");
    exe_enable = 1'b1;
    repeat (3) step();
    rd(CSR_MINSTRET, 32'd0, "minstret_frozen");
    csr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'd0, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, "inhibit_off");
    rd(CSR_MINSTRET, 32'd0, "minstret_start");
    rd(CSR_MINSTRET, 32'd1, "minstret_inc");
    exe_enable = 1'b0;
    csr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, "mcycle_wr");
    csr(CSR_OP_RW, CSR_MCYCLEH, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, "mcycleh_wr");
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_max");
    rd(CSR_MCYCLEH, 32'd0, "mcycleh_wrapped");
    rd(CSR_MCYCLE, 32'd1, "mcycle_after_wrap");
`else
    rd(CSR_MCYCLE, 32'd0, "mcycle_absent");
    exp_ill[exp_ill.size() - 1] = 1'b1;
    rd(CSR_MCOUNTINHIBIT, 32'd0, "mcountinhibit_absent");
    exp_ill[exp_ill.size() - 1] = 1'b1;
`endif

    // drain, then reset during an in-flight response
    step(); step();
    chk("scoreboard_drained", exp_data.size(), 32'd0);
    csr_valid = 1'b1; csr_op = CSR_OP_RW; csr_addr = 12'h7C0; csr_wdata = 32'd0;
    step();
    csr_valid = 1'b0; csr_op = 2'b00;
    chk("inflight_valid", {31'd0, csr_rdata_valid}, 32'd1);
    reset = 1'b1; #1;
    chk("async_reset_valid", {31'd0, csr_rdata_valid}, 32'd0);
    chk("async_reset_illegal", {31'd0, csr_illegal}, 32'd0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
